dff_capture_sequencer: RTL

//  Controller for a DEPTH-deep bank of D flip-flops sampling a single input bit.

---
 rtl/dff_seq_pkg.sv | 20 ++
 rtl/sample_tick_divider.sv | 47 ++++
 rtl/dff_capture_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dff_seq_pkg.sv
// ---------------------------------------------------------------------------
// dff_seq_pkg
//   Shared definitions for the DFF capture sequencer:
//     - ST_W        : width of the state encoding driven on the state port
//     - seq_state_t : sequencer state type; encodings are visible on the
//                     state output, so they must not be reordered.
// ---------------------------------------------------------------------------
package dff_seq_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    FULL    = 3'd3,
    REPLAY  = 3'd4
  } seq_state_t;

endpackage : dff_seq_pkg

// File: rtl/sample_tick_divider.sv
// ---------------------------------------------------------------------------
// sample_tick_divider
//   Free-running modulo-(div+1) counter that marks sample instants.
//   Ports:
//     clk    in   1      clock
//     rst_n  in   1      asynchronous active-low reset
//     clr    in   1      forces the count back to 0 (dominates en)
//     en     in   1      count enable
//     div    in   DIV_W  terminal count (period minus 1)
//     tick   out  1      high on the cycle the count equals div
// ---------------------------------------------------------------------------
module sample_tick_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Combinational so the owner can act on the same edge the count
  // reaches div; the count wraps to 0 on that edge.
  assign tick = en && !clr && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : sample_tick_divider

// File: rtl/dff_capture_sequencer.sv
// ---------------------------------------------------------------------------
// dff_capture_sequencer
//   Controls a DEPTH-deep bank of flops sampling din. Arms on command,
//   waits for a trigger, captures DEPTH samples at a programmable rate,
//   holds them, and replays them serially one bit per clock on demand.
//   Ports:
//     clk       in   1      clock
//     rst_n     in   1      asynchronous active-low reset
//     din       in   1      data bit to capture
//     arm       in   1      starts a new capture sequence
//     trig      in   1      starts sampling while ARMED
//     replay    in   1      starts serial replay while FULL
//     abort     in   1      forces IDLE from any state
//     div       in   DIV_W  sample period minus 1 (latched on trigger)
//     cap_data  out  DEPTH  captured bank, sample k in bit k
//     qout      out  1      serial replay bit
//     qvalid    out  1      qout carries a replayed bit
//     done      out  1      one-cycle pulse when the bank fills
//     busy      out  1      state is ARMED, CAPTURE or REPLAY
//     state     out  3      current state encoding
//   Legal DEPTH range is 2..16.
// ---------------------------------------------------------------------------
module dff_capture_sequencer
  import dff_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             arm,
  input  logic             trig,
  input  logic             replay,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  output logic [DEPTH-1:0] cap_data,
  output logic             qout,
  output logic             qvalid,
  output logic             done,
  output logic             busy,
  output logic [ST_W-1:0]  state
);

  // One extra bit so idx can step past DEPTH-1 without wrapping.
  localparam int IDX_W = $clog2(DEPTH) + 1;

  seq_state_t       state_q,   state_d;
  logic [DEPTH-1:0] cap_q,     cap_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [DIV_W-1:0] div_lat_q, div_lat_d;
  logic             qout_q,    qout_d;
  logic             qvalid_q,  qvalid_d;
  logic             done_q,    done_d;

  logic [DEPTH-1:0] idx_sel;
  logic             idx_last;
  logic             tick;

  // One-hot decode of idx: used both to write the capture bit and to
  // select the replay bit, avoiding an oversized bit-select index.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_idx_sel
    assign idx_sel[gi] = (idx_q == IDX_W'(gi));
  end

  assign idx_last = (idx_q == IDX_W'(DEPTH - 1));

  // The divider only runs in CAPTURE; everywhere else it is held at 0,
  // so the trigger edge always leaves it at 0 for the first period.
  sample_tick_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != CAPTURE),
    .en    (state_q == CAPTURE),
    .div   (div_lat_q),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    idx_d     = idx_q;
    div_lat_d = div_lat_q;
    qout_d    = qout_q;
    qvalid_d  = 1'b0;
    done_d    = 1'b0;

    if (abort) begin
      // cap_data is deliberately retained so a partial capture can be read.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm) begin
            state_d = ARMED;
            cap_d   = '0;
          end
        end

        ARMED: begin
          if (arm) begin
            cap_d = '0;
          end else if (trig) begin
            // The trigger edge itself takes sample 0.
            state_d   = CAPTURE;
            cap_d[0]  = din;
            idx_d     = IDX_W'(1);
            div_lat_d = div;
          end
        end

        CAPTURE: begin
          if (tick) begin
            cap_d = (cap_q & ~idx_sel) | (idx_sel & {DEPTH{din}});
            idx_d = idx_q + 1'b1;
            if (idx_last) begin
              state_d = FULL;
              done_d  = 1'b1;
            end
          end
        end

        FULL: begin
          if (replay) begin
            state_d = REPLAY;
            idx_d   = '0;
          end else if (arm) begin
            state_d = ARMED;
            cap_d   = '0;
          end
        end

        REPLAY: begin
          qout_d   = |(cap_q & idx_sel);
          qvalid_d = 1'b1;
          idx_d    = idx_q + 1'b1;
          if (idx_last) begin
            state_d = FULL;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cap_q     <= '0;
      idx_q     <= '0;
      div_lat_q <= '0;
      qout_q    <= 1'b0;
      qvalid_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      idx_q     <= idx_d;
      div_lat_q <= div_lat_d;
      qout_q    <= qout_d;
      qvalid_q  <= qvalid_d;
      done_q    <= done_d;
    end
  end

  assign cap_data = cap_q;
  assign qout     = qout_q;
  assign qvalid   = qvalid_q;
  assign done     = done_q;
  assign state    = state_q;
  assign busy     = (state_q == ARMED) || (state_q == CAPTURE) || (state_q == REPLAY);

endmodule : dff_capture_sequencer
